// File: rtl/dm_store_buffer_pkg.sv
// Shared definitions for the data-memory store buffer: FSM encodings and entry field widths.
package dm_store_buffer_pkg;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_BUSY  = 2'd1,
    SB_FLUSH = 2'd2
  } sb_state_e;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int OFS_W  = 2;   // byte-offset bits dropped to form a word address

  localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/sb_fifo.sv
// Store-buffer queue: entry regfile, pointers, occupancy count, and a per-entry
// word-address match vector used for the load hazard check.
module sb_fifo
  import dm_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WW    = 30
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WW-1:0]            push_word,
  input  logic [BE_W-1:0]          push_be,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic [WW-1:0]            match_word,
  output logic [WW-1:0]            head_word,
  output logic [BE_W-1:0]          head_be,
  output logic [DATA_W-1:0]        head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DEPTH-1:0]         hit_vec
);

  localparam int PW = $clog2(DEPTH);

  logic [WW-1:0]     word_q [DEPTH];
  logic [BE_W-1:0]   be_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;

  // NOTE: the payload arrays are deliberately not reset; valid_q qualifies every
  // use, so resetting them would only add reset fan-out to a plain regfile.
  always_ff @(posedge clk) begin
    if (push) begin
      word_q[wr_ptr] <= push_word;
      be_q[wr_ptr]   <= push_be;
      data_q[wr_ptr] <= push_data;
    end
  end

  // NOTE: sequential state is always updated with <= so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      if (push) begin
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec[i] = valid_q[i] & (word_q[i] == match_word);
    end
  end

  assign head_word = word_q[rd_ptr];
  assign head_be   = be_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

endmodule

// File: rtl/dm_store_buffer.sv
// Posted-write buffer in front of the single-port data memory: queues stores,
// drains them when loads leave the port free, and stalls loads that hit a queued word.
module dm_store_buffer
  import dm_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [AW-1:0]     st_addr,
  input  logic [BE_W-1:0]   st_be,
  input  logic [DATA_W-1:0] st_wdata,
  input  logic              ld_valid,
  input  logic [AW-1:0]     ld_addr,
  output logic              ld_stall,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              empty,
  output logic [AW-1:0]     dm_addr,
  output logic              dm_we,
  output logic [BE_W-1:0]   dm_be,
  output logic [DATA_W-1:0] dm_wdata
);

  localparam int WW = AW - OFS_W;
  localparam int CW = $clog2(DEPTH) + 1;

  sb_state_e         state;
  logic              flush_armed;
  logic [CW-1:0]     count;
  logic [DEPTH-1:0]  hit_vec;
  logic [WW-1:0]     head_word;
  logic [BE_W-1:0]   head_be;
  logic [DATA_W-1:0] head_data;
  logic              hit, flushing, push, pop, load_owns;
  logic              st_addr_unused;

  // Store byte offset is irrelevant: entries are tracked per word.
  assign st_addr_unused = ^st_addr[OFS_W-1:0];

  sb_fifo #(.DEPTH(DEPTH), .WW(WW)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_word  (st_addr[AW-1:OFS_W]),
    .push_be    (st_be),
    .push_data  (st_wdata),
    .pop        (pop),
    .match_word (ld_addr[AW-1:OFS_W]),
    .head_word  (head_word),
    .head_be    (head_be),
    .head_data  (head_data),
    .count      (count),
    .hit_vec    (hit_vec)
  );

  assign flushing  = (state == SB_FLUSH);
  assign hit       = ld_valid & (|hit_vec);
  assign st_ready  = (count < CW'(DEPTH)) & !flushing;
  assign push      = st_valid & st_ready & (|st_be);
  assign load_owns = ld_valid & !hit & !flushing;
  assign pop       = (count != '0) & !load_owns;

  assign empty      = (count == '0);
  assign ld_stall   = ld_valid & (hit | flushing);
  assign flush_done = flushing & empty;

  assign dm_we    = pop;
  assign dm_addr  = pop ? {head_word, {OFS_W{1'b0}}} : ld_addr;
  assign dm_be    = pop ? head_be   : '0;
  assign dm_wdata = pop ? head_data : '0;

  // flush_armed blocks re-entry into FLUSH until flush_req has been seen low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SB_IDLE;
      flush_armed <= 1'b1;
    end else begin
      case (state)
        SB_IDLE: begin
          if (flush_req && flush_armed) begin
            state       <= SB_FLUSH;
            flush_armed <= 1'b0;
          end else if (push) begin
            state <= SB_BUSY;
          end
        end
        SB_BUSY: begin
          if (flush_req && flush_armed) begin
            state       <= SB_FLUSH;
            flush_armed <= 1'b0;
          end else if (pop && !push && count == CW'(1)) begin
            state <= SB_IDLE;
          end
        end
        SB_FLUSH: begin
          if (empty) state <= SB_IDLE;
        end
        default: state <= SB_IDLE;
      endcase
      if (!flush_req) flush_armed <= 1'b1;
    end
  end

endmodule
